snake_game_fsm: RTL and testbench

Top-level game sequencer for the Snakes game. It consumes the single-cycle pulses produced by the edge-detect stage (good/bad collision, button, direction) and runs the game state machine. It generates the periodic snake move tick, arbitrates direction changes with a no-reversal rule, and maintains the score and snake length consumed by the board/display logic.

---
 rtl/snake_game_fsm.sv | 124 ++++++++++++
 tb/tb_snake_game_fsm.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/snake_game_fsm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// snake_game_fsm : game sequencer - move tick, heading arbitration, score/length
// Rev 1.0
// ---------------------------------------------------------------------------
module snake_game_fsm #(
  parameter int TICK_DIV = 1_000_000,
  parameter int MAX_LEN  = 50
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       goodColl,
  input  logic       badColl,
  input  logic       button,
  input  logic [3:0] direction,
  output logic [1:0] state,
  output logic       move_tick,
  output logic [3:0] dir_q,
  output logic [6:0] length,
  output logic [7:0] score,
  output logic       grow,
  output logic       win
);

  localparam int            CW     = $clog2(TICK_DIV);
  localparam logic [CW-1:0] C_LAST = CW'(TICK_DIV - 1);
  localparam logic [6:0]    C_MAX  = 7'(MAX_LEN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_OVER  = 2'b11
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_pending;

  logic       w_onehot;
  logic [3:0] w_opposite;
  logic       w_dir_ok;
  logic [3:0] w_next_pend;
  logic [6:0] w_len_inc;
  logic       w_leave_run;

  assign state       = r_state;
  assign w_onehot    = (direction != 4'b0000) && ((direction & (direction - 4'd1)) == 4'b0000);
  // swap up<->down and left<->right
  assign w_opposite  = {dir_q[2], dir_q[3], dir_q[0], dir_q[1]};
  assign w_dir_ok    = w_onehot && (direction != dir_q) && (direction != w_opposite);
  assign w_next_pend = w_dir_ok ? direction : r_pending;
  assign w_len_inc   = length + 7'd1;
  assign w_leave_run = badColl || (goodColl && (w_len_inc == C_MAX)) || (!goodColl && button);

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_pending <= 4'b0001;
      move_tick <= 1'b0;
      dir_q     <= 4'b0001;
      length    <= 7'd2;
      score     <= 8'd0;
      grow      <= 1'b0;
      win       <= 1'b0;
    end else begin
      move_tick <= 1'b0;
      grow      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (button) begin
            r_state   <= S_RUN;
            r_cnt     <= '0;
            r_pending <= 4'b0001;
            dir_q     <= 4'b0001;
            length    <= 7'd2;
            score     <= 8'd0;
            win       <= 1'b0;
          end
        end
        S_RUN: begin
          if (badColl) begin
            r_state <= S_OVER;
            win     <= 1'b0;
          end else if (goodColl) begin
            score  <= score + 8'd1;
            length <= w_len_inc;
            grow   <= 1'b1;
            if (w_len_inc == C_MAX) begin
              r_state <= S_OVER;
              win     <= 1'b1;
            end
          end else if (button) begin
            r_state <= S_PAUSE;
          end

          // A tick due in a cycle that leaves RUN is held until counting resumes
          if (!w_leave_run) begin
            r_pending <= w_next_pend;
            if (r_cnt == C_LAST) begin
              r_cnt     <= '0;
              move_tick <= 1'b1;
              dir_q     <= w_next_pend;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end else if (r_cnt != C_LAST) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_PAUSE: begin
          if (button) r_state <= S_RUN;
        end
        S_OVER: begin
          if (button) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_snake_game_fsm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_snake_game_fsm : directed vector bench for snake_game_fsm (TICK_DIV=4, MAX_LEN=4)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_snake_game_fsm;

  logic       clk = 1'b0;
  logic       nRst;
  logic       goodColl, badColl, button;
  logic [3:0] direction;
  logic [1:0] state;
  logic       move_tick;
  logic [3:0] dir_q;
  logic [6:0] length;
  logic [7:0] score;
  logic       grow;
  logic       win;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  snake_game_fsm #(.TICK_DIV(4), .MAX_LEN(4)) dut (
    .clk(clk), .nRst(nRst), .goodColl(goodColl), .badColl(badColl),
    .button(button), .direction(direction), .state(state),
    .move_tick(move_tick), .dir_q(dir_q), .length(length),
    .score(score), .grow(grow), .win(win)
  );

  typedef struct {
    logic       btn, good, bad;
    logic [3:0] dir;
    logic [1:0] st;
    logic       mt;
    logic [3:0] dq;
    logic [6:0] len;
    logic [7:0] sc;
    logic       gr, wn;
  } vec_t;

  vec_t vecs[39];

  function automatic vec_t mk(input logic b, g, bd, input logic [3:0] d,
                              input logic [1:0] st, input logic mt, input logic [3:0] dq,
                              input logic [6:0] len, input logic [7:0] sc,
                              input logic gr, wn);
    vec_t v;
    v.btn = b; v.good = g; v.bad = bd; v.dir = d;
    v.st = st; v.mt = mt; v.dq = dq; v.len = len; v.sc = sc; v.gr = gr; v.wn = wn;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] st, input logic mt,
                           input logic [3:0] dq, input logic [6:0] len, input logic [7:0] sc,
                           input logic gr, input logic wn);
    check({tag, ".state"}, 32'(state), 32'(st));
    check({tag, ".move_tick"}, 32'(move_tick), 32'(mt));
    check({tag, ".dir_q"}, 32'(dir_q), 32'(dq));
    check({tag, ".length"}, 32'(length), 32'(len));
    check({tag, ".score"}, 32'(score), 32'(sc));
    check({tag, ".grow"}, 32'(grow), 32'(gr));
    check({tag, ".win"}, 32'(win), 32'(wn));
  endtask

  task automatic drive(input logic b, g, bd, input logic [3:0] d);
    button = b; goodColl = g; badColl = bd; direction = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //           btn good bad dir     st    mt dq    len sc gr win
    vecs[0]  = mk(1, 0, 0, 4'h0, 2'd1, 0, 4'h1, 2, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 4'h0, 2'd1, 0, 4'h1, 2, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 4'h8, 2'd1, 0, 4'h1, 2, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0, 4'h0, 2'd1, 0, 4'h1, 2, 0, 0, 0);
    vecs[4]  = mk(0, 0, 0, 4'h0, 2'd1, 1, 4'h8, 2, 0, 0, 0);
    vecs[5]  = mk(0, 0, 0, 4'h2, 2'd1, 0, 4'h8, 2, 0, 0, 0);
    vecs[6]  = mk(0, 0, 0, 4'h4, 2'd1, 0, 4'h8, 2, 0, 0, 0);
    vecs[7]  = mk(0, 0, 0, 4'hA, 2'd1, 0, 4'h8, 2, 0, 0, 0);
    vecs[8]  = mk(0, 0, 0, 4'h0, 2'd1, 1, 4'h2, 2, 0, 0, 0);
    vecs[9]  = mk(0, 0, 0, 4'h1, 2'd1, 0, 4'h2, 2, 0, 0, 0);
    vecs[10] = mk(0, 0, 0, 4'h2, 2'd1, 0, 4'h2, 2, 0, 0, 0);
    vecs[11] = mk(0, 0, 0, 4'h0, 2'd1, 0, 4'h2, 2, 0, 0, 0);
    vecs[12] = mk(0, 0, 0, 4'h0, 2'd1, 1, 4'h2, 2, 0, 0, 0);
    vecs[13] = mk(0, 0, 0, 4'h0, 2'd1, 0, 4'h2, 2, 0, 0, 0);
    vecs[14] = mk(0, 0, 0, 4'h0, 2'd1, 0, 4'h2, 2, 0, 0, 0);
    vecs[15] = mk(0, 0, 0, 4'h0, 2'd1, 0, 4'h2, 2, 0, 0, 0);
    vecs[16] = mk(0, 0, 0, 4'h8, 2'd1, 1, 4'h8, 2, 0, 0, 0);
    vecs[17] = mk(0, 1, 0, 4'h0, 2'd1, 0, 4'h8, 3, 1, 1, 0);
    vecs[18] = mk(0, 0, 0, 4'h0, 2'd1, 0, 4'h8, 3, 1, 0, 0);
    vecs[19] = mk(1, 0, 0, 4'h0, 2'd2, 0, 4'h8, 3, 1, 0, 0);
    vecs[20] = mk(0, 1, 0, 4'h0, 2'd2, 0, 4'h8, 3, 1, 0, 0);
    vecs[21] = mk(0, 0, 1, 4'h0, 2'd2, 0, 4'h8, 3, 1, 0, 0);
    vecs[22] = mk(0, 0, 0, 4'h2, 2'd2, 0, 4'h8, 3, 1, 0, 0);
    vecs[23] = mk(0, 0, 0, 4'h0, 2'd2, 0, 4'h8, 3, 1, 0, 0);
    vecs[24] = mk(1, 0, 0, 4'h0, 2'd1, 0, 4'h8, 3, 1, 0, 0);
    vecs[25] = mk(0, 0, 0, 4'h0, 2'd1, 1, 4'h8, 3, 1, 0, 0);
    vecs[26] = mk(0, 1, 0, 4'h0, 2'd3, 0, 4'h8, 4, 2, 1, 1);
    vecs[27] = mk(0, 0, 0, 4'h0, 2'd3, 0, 4'h8, 4, 2, 0, 1);
    vecs[28] = mk(1, 0, 0, 4'h0, 2'd0, 0, 4'h8, 4, 2, 0, 1);
    vecs[29] = mk(0, 1, 0, 4'h0, 2'd0, 0, 4'h8, 4, 2, 0, 1);
    vecs[30] = mk(1, 0, 0, 4'h0, 2'd1, 0, 4'h1, 2, 0, 0, 0);
    vecs[31] = mk(0, 1, 1, 4'h0, 2'd3, 0, 4'h1, 2, 0, 0, 0);
    vecs[32] = mk(1, 0, 0, 4'h0, 2'd0, 0, 4'h1, 2, 0, 0, 0);
    vecs[33] = mk(1, 0, 0, 4'h0, 2'd1, 0, 4'h1, 2, 0, 0, 0);
    vecs[34] = mk(1, 1, 0, 4'h0, 2'd1, 0, 4'h1, 3, 1, 1, 0);
    vecs[35] = mk(1, 0, 1, 4'h8, 2'd3, 0, 4'h1, 3, 1, 0, 0);
    vecs[36] = mk(1, 0, 0, 4'h0, 2'd0, 0, 4'h1, 3, 1, 0, 0);
    vecs[37] = mk(1, 0, 0, 4'h0, 2'd1, 0, 4'h1, 2, 0, 0, 0);
    vecs[38] = mk(0, 1, 0, 4'h0, 2'd1, 0, 4'h1, 3, 1, 1, 0);

    nRst = 1'b0; button = 1'b0; goodColl = 1'b0; badColl = 1'b0; direction = 4'h0;
    repeat (2) @(posedge clk);
    #1 nRst = 1'b1;
    check_all("reset", 2'd0, 0, 4'h1, 2, 0, 0, 0);

    for (int i = 0; i < 39; i++) begin
      drive(vecs[i].btn, vecs[i].good, vecs[i].bad, vecs[i].dir);
      check_all($sformatf("v%0d", i), vecs[i].st, vecs[i].mt, vecs[i].dq,
                vecs[i].len, vecs[i].sc, vecs[i].gr, vecs[i].wn);
    end

    // asynchronous reset mid-RUN with score=1 and grow high
    button = 1'b0; goodColl = 1'b0; badColl = 1'b0; direction = 4'h0;
    #2 nRst = 1'b0;
    #1 check_all("async_rst", 2'd0, 0, 4'h1, 2, 0, 0, 0);
    @(posedge clk);
    #1 nRst = 1'b1;

    // first post-reset cycle is IDLE: collisions ignored
    drive(0, 1, 0, 4'h0);
    check_all("post_rst_idle", 2'd0, 0, 4'h1, 2, 0, 0, 0);
    drive(1, 0, 0, 4'h0);
    check_all("post_rst_run", 2'd1, 0, 4'h1, 2, 0, 0, 0);

    // direction in a cycle that leaves RUN must be discarded
    drive(1, 0, 0, 4'h8);
    check_all("dir_on_pause", 2'd2, 0, 4'h1, 2, 0, 0, 0);
    drive(1, 0, 0, 4'h0);
    check("resume.state", 32'(state), 32'd1);
    drive(0, 0, 0, 4'h0);
    check("resume.c3.tick", 32'(move_tick), 32'd0);
    drive(0, 0, 0, 4'h0);
    check("resume.c4.tick", 32'(move_tick), 32'd0);
    drive(0, 0, 0, 4'h0);
    check("resume.c5.tick", 32'(move_tick), 32'd1);
    check("resume.c5.dir_q", 32'(dir_q), 32'h1);
    drive(0, 0, 0, 4'h0);
    check("resume.c6.tick", 32'(move_tick), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
